// File: rtl/frame_zbuf_mem.sv
// Frame buffer (PIX_W) and depth buffer (Z_W) BRAMs with a hardware clear sequencer and
// 1-cycle read ports. Optional macro ZB_FORWARD_EN adds write-to-read bypass on the depth port.
module frame_zbuf_mem #(
   parameter int unsigned H_RES  = 320,
   parameter int unsigned V_RES  = 240,
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned PIX_W  = 12,
   parameter int unsigned Z_W    = 8,
   parameter logic [PIX_W-1:0] CLEAR_PIXEL = '0,
   parameter logic [Z_W-1:0]   CLEAR_Z     = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_zb_r_addr,
   output logic [Z_W-1:0]    o_zb_r_data,
   input  logic [ADDR_W-1:0] i_zb_w_addr,
   input  logic              i_zb_w_we,
   input  logic [Z_W-1:0]    i_zb_w_data,
   input  logic [ADDR_W-1:0] i_fb_addr,
   input  logic              i_fb_we,
   input  logic [PIX_W-1:0]  i_fb_pixel,
   input  logic              i_clear_start,
   output logic              o_clear_busy,
   output logic              o_clear_done,
   input  logic [ADDR_W-1:0] i_scan_addr,
   output logic [PIX_W-1:0]  o_scan_pixel,
   output logic              o_drop_err
);

   localparam int unsigned       DEPTH     = H_RES * V_RES;
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clearing;

   logic              fb_w_ok, zb_w_ok, zb_r_ok, scan_ok;
   logic              fb_wen, zb_wen;
   logic [ADDR_W-1:0] fb_wa, zb_wa;
   logic [PIX_W-1:0]  fb_wd;
   logic [Z_W-1:0]    zb_wd;

   logic [PIX_W-1:0]  fb_mem [DEPTH];
   logic [Z_W-1:0]    zb_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      o_clear_busy = 1'b0;
      o_clear_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_clear_start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            o_clear_busy = 1'b1;
            if (cnt_q == LAST_ADDR) state_d = S_DONE;
            else                    cnt_d   = cnt_q + ADDR_W'(1);
         end
         S_DONE: begin
            o_clear_done = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign clearing = (state_q == S_CLEAR);
   assign fb_w_ok  = {1'b0, i_fb_addr}   < DEPTH_X;
   assign zb_w_ok  = {1'b0, i_zb_w_addr} < DEPTH_X;
   assign zb_r_ok  = {1'b0, i_zb_r_addr} < DEPTH_X;
   assign scan_ok  = {1'b0, i_scan_addr} < DEPTH_X;

   // The clear sequencer owns both write ports while active; rasterizer writes are dropped.
   always_comb begin
      fb_wen = 1'b0;
      fb_wa  = i_fb_addr;
      fb_wd  = i_fb_pixel;
      zb_wen = 1'b0;
      zb_wa  = i_zb_w_addr;
      zb_wd  = i_zb_w_data;
      if (clearing) begin
         fb_wen = 1'b1;
         fb_wa  = cnt_q;
         fb_wd  = CLEAR_PIXEL;
         zb_wen = 1'b1;
         zb_wa  = cnt_q;
         zb_wd  = CLEAR_Z;
      end else begin
         fb_wen = i_fb_we && fb_w_ok;
         zb_wen = i_zb_w_we && zb_w_ok;
      end
      fb_wen = fb_wen && rst_n;
      zb_wen = zb_wen && rst_n;
   end

   always_ff @(posedge clk) begin
      if (fb_wen) fb_mem[fb_wa] <= fb_wd;
   end

   always_ff @(posedge clk) begin
      if (zb_wen) zb_mem[zb_wa] <= zb_wd;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)        o_scan_pixel <= '0;
      else if (!scan_ok) o_scan_pixel <= '0;
      else               o_scan_pixel <= fb_mem[i_scan_addr];
   end

`ifdef ZB_FORWARD_EN
   logic              fwd_now, fwd_prev;
   logic              prev_we;
   logic [ADDR_W-1:0] prev_addr;
   logic [Z_W-1:0]    prev_data;

   // Bypass only rasterizer writes; during a clear the read sees raw memory.
   assign fwd_now  = zb_wen && !clearing && (i_zb_w_addr == i_zb_r_addr);
   assign fwd_prev = prev_we && !clearing && (prev_addr == i_zb_r_addr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_we   <= 1'b0;
         prev_addr <= '0;
         prev_data <= '0;
      end else begin
         prev_we   <= zb_wen && !clearing;
         prev_addr <= i_zb_w_addr;
         prev_data <= i_zb_w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)        o_zb_r_data <= '0;
      else if (!zb_r_ok) o_zb_r_data <= '0;
      else if (fwd_now)  o_zb_r_data <= i_zb_w_data;
      else if (fwd_prev) o_zb_r_data <= prev_data;
      else               o_zb_r_data <= zb_mem[i_zb_r_addr];
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n)        o_zb_r_data <= '0;
      else if (!zb_r_ok) o_zb_r_data <= '0;
      else               o_zb_r_data <= zb_mem[i_zb_r_addr];
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)                                     o_drop_err <= 1'b0;
      else if (clearing && (i_fb_we || i_zb_w_we))    o_drop_err <= 1'b1;
   end

endmodule

// File: tb/tb_frame_zbuf_mem.sv
// Self-checking bench for frame_zbuf_mem on a reduced 80x100 frame; honours ZB_FORWARD_EN.
module tb_frame_zbuf_mem;

   localparam int unsigned H = 80, V = 100, AW = 13, PW = 12, ZW = 8;
   localparam int DEPTH = H * V;
`ifdef ZB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] i_zb_r_addr, i_zb_w_addr, i_fb_addr, i_scan_addr;
   logic [ZW-1:0] o_zb_r_data, i_zb_w_data;
   logic [PW-1:0] i_fb_pixel, o_scan_pixel;
   logic          i_zb_w_we, i_fb_we, i_clear_start;
   logic          o_clear_busy, o_clear_done, o_drop_err;

   always #5 clk = ~clk;

   frame_zbuf_mem #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(PW), .Z_W(ZW),
                    .CLEAR_PIXEL(12'h000), .CLEAR_Z(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_zb_r_addr(i_zb_r_addr), .o_zb_r_data(o_zb_r_data),
      .i_zb_w_addr(i_zb_w_addr), .i_zb_w_we(i_zb_w_we), .i_zb_w_data(i_zb_w_data),
      .i_fb_addr(i_fb_addr), .i_fb_we(i_fb_we), .i_fb_pixel(i_fb_pixel),
      .i_clear_start(i_clear_start), .o_clear_busy(o_clear_busy), .o_clear_done(o_clear_done),
      .i_scan_addr(i_scan_addr), .o_scan_pixel(o_scan_pixel), .o_drop_err(o_drop_err)
   );

   logic [PW-1:0] fb_m [DEPTH];
   logic [ZW-1:0] zb_m [DEPTH];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_fb_we       = 1'b0;
      i_zb_w_we     = 1'b0;
      i_clear_start = 1'b0;
   endtask

   // One non-clearing cycle: predicts both read ports from the array model, then commits writes.
   task automatic drive(input string tag, input bit fwe, input int fa, input logic [PW-1:0] fd,
                        input bit zwe, input int zwa, input logic [ZW-1:0] zwd,
                        input int zra, input int sa);
      logic [ZW-1:0] ez;
      logic [PW-1:0] es;
      if (zra >= DEPTH)                    ez = '0;
      else if (FWD && zwe && zwa == zra)   ez = zwd;
      else                                 ez = zb_m[zra];
      es = (sa >= DEPTH) ? '0 : fb_m[sa];
      i_clear_start = 1'b0;
      i_fb_we = fwe;      i_fb_addr   = AW'(fa);  i_fb_pixel  = fd;
      i_zb_w_we = zwe;    i_zb_w_addr = AW'(zwa); i_zb_w_data = zwd;
      i_zb_r_addr = AW'(zra);
      i_scan_addr = AW'(sa);
      step();
      chk({tag, "_zb"}, o_zb_r_data, ez);
      if (!(fwe && fa == sa)) chk({tag, "_scan"}, o_scan_pixel, es);
      if (fwe && fa < DEPTH) fb_m[fa] = fd;
      if (zwe && zwa < DEPTH) zb_m[zwa] = zwd;
      idle_inputs();
   endtask

   // mode 0: plain; 1: re-pulse start and rasterizer writes at cycle 100; 2: reset at cycle 5000.
   task automatic run_clear(input int mode, output int pulses, output int first);
      i_clear_start = 1'b1;
      step();
      i_clear_start = 1'b0;
      chk("busy_rise", o_clear_busy, 1);
      pulses = 0;
      first  = -1;
      for (int c = 1; c <= DEPTH + 4; c++) begin
         if (mode == 1 && c == 100) begin
            i_clear_start = 1'b1;
            i_fb_we = 1'b1;   i_fb_addr   = AW'(50); i_fb_pixel  = 12'hABC;
            i_zb_w_we = 1'b1; i_zb_w_addr = AW'(60); i_zb_w_data = 8'h11;
         end
         if (mode == 2 && c == 5000) rst_n = 1'b0;
         step();
         idle_inputs();
         if (mode == 1 && c == 100) chk("drop_err_set", o_drop_err, 1);
         if (mode == 2 && c == 5000) begin
            chk("rst_busy_drop", o_clear_busy, 0);
            chk("rst_no_done", o_clear_done, 0);
            rst_n = 1'b1;
         end
         if (mode != 2 && c == DEPTH - 1) chk("busy_hold", o_clear_busy, 1);
         if (mode != 2 && c == DEPTH)     chk("busy_fall", o_clear_busy, 0);
         // cycle 1 is the one following the edge that sampled start
         if (o_clear_done) begin
            pulses++;
            if (first < 0) first = c + 1;
         end
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first, bad_fb, bad_zb;
      rst_n = 1'b0;
      idle_inputs();
      i_fb_addr = '0; i_fb_pixel = '0; i_zb_w_addr = '0; i_zb_w_data = '0;
      i_zb_r_addr = '0; i_scan_addr = '0;
      step(); step();
      chk("rst_zb_data", o_zb_r_data, 0);
      chk("rst_scan", o_scan_pixel, 0);
      chk("rst_busy", o_clear_busy, 0);
      chk("rst_done", o_clear_done, 0);
      chk("rst_drop", o_drop_err, 0);
      rst_n = 1'b1;
      step();

      // Full clear, then read every location back through both ports
      run_clear(0, pulses, first);
      chk("clr1_pulses", pulses, 1);
      chk("clr1_latency", first, DEPTH + 1);
      bad_fb = 0;
      bad_zb = 0;
      for (int a = 0; a < DEPTH; a++) begin
         i_zb_r_addr = AW'(a);
         i_scan_addr = AW'(a);
         step();
         if (o_scan_pixel !== 12'h000) bad_fb++;
         if (o_zb_r_data  !== 8'hFF)   bad_zb++;
         fb_m[a] = 12'h000;
         zb_m[a] = 8'hFF;
      end
      chk("fb_all_clear", bad_fb, 0);
      chk("zb_all_far", bad_zb, 0);

      drive("t2_zw", 0, 0, 0, 1, 1000, 8'h40, 0, 0);
      drive("t2_idle", 1, 319, 12'hF0F, 0, 0, 0, 2, 3);
      drive("t2_rd", 0, 0, 0, 0, 0, 0, 1000, 319);
      chk("t2_zb_1000", o_zb_r_data, 8'h40);
      chk("t2_fb_319", o_scan_pixel, 12'hF0F);

      drive("t3_coll", 0, 0, 0, 1, 500, 8'h22, 500, 0);
      chk("t3_coll_abs", o_zb_r_data, FWD ? 8'h22 : 8'hFF);
      drive("t3_after", 0, 0, 0, 0, 0, 0, 500, 0);

      drive("both_wr", 1, 700, 12'h123, 1, 701, 8'h07, 0, 0);
      drive("both_rd", 0, 0, 0, 0, 0, 0, 701, 700);
      drive("oor_wr", 1, DEPTH + 100, 12'h777, 1, DEPTH + 100, 8'h77, DEPTH + 100, DEPTH + 100);
      drive("oor_rd", 0, 0, 0, 0, 0, 0, DEPTH + 100, DEPTH + 191);

      for (int i = 0; i < 400; i++) begin
         int fa, zwa, zra, sa;
         fa  = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 150)) : int'($urandom_range(0, 63));
         zwa = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 150)) : int'($urandom_range(0, 63));
         zra = ($urandom_range(0, 2) == 0) ? zwa : int'($urandom_range(0, 63));
         sa  = ($urandom_range(0, 15) == 0) ? DEPTH + 5 : int'($urandom_range(0, 63));
         drive($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), fa, PW'($urandom),
               1'($urandom_range(0, 1)), zwa, ZW'($urandom), zra, sa);
      end

      // Clear with a re-pulsed start and rasterizer writes behind the clear pointer
      run_clear(1, pulses, first);
      chk("clr2_pulses", pulses, 1);
      chk("clr2_latency", first, DEPTH + 1);
      chk("drop_err_sticky", o_drop_err, 1);
      for (int a = 0; a < DEPTH; a++) begin
         fb_m[a] = 12'h000;
         zb_m[a] = 8'hFF;
      end
      drive("drop_chk", 0, 0, 0, 0, 0, 0, 60, 50);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("drop_err_rst", o_drop_err, 0);

      // Reset part-way through a clear leaves the tail untouched
      drive("pre6_a", 1, 6000, 12'h5A5, 1, 6000, 8'h3C, 0, 0);
      drive("pre6_b", 1, 10, 12'hBEE, 1, 10, 8'h01, 0, 0);
      run_clear(2, pulses, first);
      chk("clr3_pulses", pulses, 0);
      fb_m[10] = 12'h000;
      zb_m[10] = 8'hFF;
      drive("t6_rd6000", 0, 0, 0, 0, 0, 0, 6000, 6000);
      drive("t6_rd10", 0, 0, 0, 0, 0, 0, 10, 10);
      chk("t6_busy_idle", o_clear_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
